// File: rtl/fir61_out_requant.sv
// Output stage for the 61-tap DA FIR core. It realigns the sample strobe with the core's
// latency, rounds and saturates each result to OUT_W bits, and queues it behind valid/ready.
module fir61_out_requant #(
    parameter int IN_W    = 30,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 12,
    parameter int LATENCY = 9,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  filter_out,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AW:0]             fifo_level,
    output logic                    ovf,
    output logic [CNT_W-1:0]        sat_cnt,
    input  logic                    clr
);

    localparam logic signed [IN_W:0] HALF  = (IN_W + 1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAX_R = (IN_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] MIN_R = -MAX_R - (IN_W + 1)'(1);
    localparam logic [AW:0]          FULL  = (AW + 1)'(DEPTH);

    // filter_out is updated on edge k+LATENCY, so it is sampled one edge later;
    // the extra flop lines the strobe up with that sampling edge.
    logic [LATENCY:0] vdl;
    logic             v_al;

    logic signed [IN_W:0]      t_sum;
    logic signed [IN_W:0]      r_shift;
    logic signed [OUT_W-1:0]   q_next;
    logic                      sat_next;

    logic                      rq_valid;
    logic signed [OUT_W-1:0]   rq_data;
    logic                      rq_sat;

    logic signed [OUT_W-1:0]   mem [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [AW:0]               level;
    logic                      pop;
    logic                      push_ok;

    assign v_al = vdl[LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vdl <= '0;
        end else begin
            vdl <= {vdl[LATENCY-1:0], in_valid};
        end
    end

    always_comb begin
        t_sum    = {filter_out[IN_W-1], filter_out} + HALF;
        r_shift  = t_sum >>> SHIFT;
        q_next   = r_shift[OUT_W-1:0];
        sat_next = 1'b0;
        if (r_shift > MAX_R) begin
            q_next   = MAX_R[OUT_W-1:0];
            sat_next = 1'b1;
        end else if (r_shift < MIN_R) begin
            q_next   = MIN_R[OUT_W-1:0];
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_valid <= 1'b0;
            rq_data  <= '0;
            rq_sat   <= 1'b0;
        end else begin
            rq_valid <= v_al;
            if (v_al) begin
                rq_data <= q_next;
                rq_sat  <= sat_next;
            end
        end
    end

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign pop     = out_valid && out_ready;
    assign push_ok = rq_valid && ((level != FULL) || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= rq_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf     <= 1'b0;
            sat_cnt <= '0;
        end else if (clr) begin
            ovf     <= 1'b0;
            sat_cnt <= '0;
        end else begin
            if (rq_valid && !push_ok) begin
                ovf <= 1'b1;
            end
            if (rq_valid && rq_sat && (sat_cnt != {CNT_W{1'b1}})) begin
                sat_cnt <= sat_cnt + 1'b1;
            end
        end
    end

    assign out_valid  = (level != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;

endmodule

// File: tb/tb_fir61_out_requant.sv
// Randomised and directed bench for fir61_out_requant, checked against a queue-based model
// of the strobe timing, rounding/saturation arithmetic and FIFO occupancy.
module tb_fir61_out_requant;

    localparam int LAT   = 9;
    localparam int DEPTH = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic signed [29:0]  filter_out = '0;
    logic signed [15:0]  out_data;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [4:0]          fifo_level;
    logic                ovf;
    logic [15:0]         sat_cnt;
    logic                clr = 1'b0;

    fir61_out_requant dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .filter_out(filter_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .ovf(ovf), .sat_cnt(sat_cnt), .clr(clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 t;
        logic signed [15:0] q;
        bit                 s;
    } arrival_t;

    arrival_t            arr[$];
    logic signed [15:0]  mq[$];
    logic signed [15:0]  pops[$];
    logic signed [29:0]  fo_at[int];
    bit                  movf;
    int                  msat;
    int                  cyc;
    int                  checks;
    int                  failures;
    int                  vld_cnt;
    int                  first_vld;

    task automatic checkOutput(input string tag, input logic signed [63:0] act,
                               input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Round-half-up division by 4096 done with integer floor division, then clamp.
    function automatic arrival_t requant(input longint x, input int t);
        arrival_t a;
        longint   n;
        longint   r;
        n = x + 2048;
        if (n >= 0) r = n / 4096;
        else        r = -((-n + 4095) / 4096);
        a.t = t;
        a.s = 1'b0;
        if (r > 32767) begin
            a.q = 16'sd32767;
            a.s = 1'b1;
        end else if (r < -32768) begin
            a.q = -16'sd32768;
            a.s = 1'b1;
        end else begin
            a.q = 16'(r);
        end
        return a;
    endfunction

    // One clock: drive inputs, model the edge, then present filter_out and compare.
    task automatic applyStimulus(input bit v, input logic signed [29:0] val,
                                 input bit rdy, input bit c);
        arrival_t a;
        bit       pop;
        bit       have;
        in_valid  = v;
        out_ready = rdy;
        clr       = c;
        if (out_valid && rdy) pops.push_back(out_data);
        @(posedge clk);
        cyc++;
        pop  = (mq.size() != 0) && rdy;
        have = (arr.size() != 0) && (arr[0].t == cyc);
        if (have) begin
            a = arr.pop_front();
            if (a.s && msat < 65535) msat++;
        end
        if (pop) void'(mq.pop_front());
        if (have) begin
            if (mq.size() < DEPTH) mq.push_back(a.q);
            else                   movf = 1'b1;
        end
        if (c) begin
            msat = 0;
            movf = 1'b0;
        end
        if (v) begin
            fo_at[cyc + LAT] = val;
            arr.push_back(requant(longint'(val), cyc + LAT + 2));
        end
        #1;
        if (fo_at.exists(cyc)) begin
            filter_out = fo_at[cyc];
            fo_at.delete(cyc);
        end else begin
            filter_out = 30'($urandom);
        end
        checkOutput("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) checkOutput("out_data", out_data, mq[0]);
        checkOutput("fifo_level", fifo_level, mq.size());
        checkOutput("ovf", ovf, movf);
        checkOutput("sat_cnt", sat_cnt, msat);
        if (out_valid) begin
            vld_cnt++;
            if (first_vld < 0) first_vld = cyc;
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, rdy, 1'b0);
    endtask

    task automatic sendOne(input logic signed [29:0] val, input logic signed [15:0] exp,
                           input string tag);
        pops.delete();
        applyStimulus(1'b1, val, 1'b1, 1'b0);
        idle(14, 1'b1);
        checkOutput({tag, "_count"}, pops.size(), 1);
        if (pops.size() != 0) checkOutput(tag, pops[0], exp);
    endtask

    task automatic asyncReset();
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_fifo_level", fifo_level, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_sat_cnt", sat_cnt, 0);
        arr.delete();
        mq.delete();
        fo_at.delete();
        pops.delete();
        movf = 1'b0;
        msat = 0;
        in_valid = 1'b0;
        clr = 1'b0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int c0;
        longint x;
        checks = 0;
        failures = 0;
        cyc = 0;
        vld_cnt = 0;
        first_vld = -1;
        movf = 1'b0;
        msat = 0;

        asyncReset();

        sendOne(30'sd409600, 16'sd100, "scale_100");
        checkOutput("scale_sat_cnt", sat_cnt, 0);
        sendOne(30'sd2048, 16'sd1, "round_p2048");
        sendOne(-30'sd2048, 16'sd0, "round_m2048");
        sendOne(-30'sd2049, -16'sd1, "round_m2049");
        sendOne(30'sd2047, 16'sd0, "round_p2047");

        sendOne(30'sd268435456, 16'sd32767, "sat_pos");
        sendOne(-30'sd536870912, -16'sd32768, "sat_neg");
        checkOutput("sat_cnt_two", sat_cnt, 2);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("sat_cnt_clr", sat_cnt, 0);

        vld_cnt = 0;
        first_vld = -1;
        c0 = cyc + 1;
        applyStimulus(1'b1, 30'sd4096, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("lat_first", first_vld, c0 + LAT + 2);
        checkOutput("lat_count", vld_cnt, 1);

        pops.delete();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 30'((i + 1) * 4096), 1'b0, 1'b0);
        idle(12, 1'b0);
        checkOutput("bp_level", fifo_level, 16);
        checkOutput("bp_ovf", ovf, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("bp_ovf_clr", ovf, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 30'((101 + i) * 4096), 1'b0, 1'b0);
        idle(7, 1'b0);
        idle(4, 1'b1);
        checkOutput("full_pp_level", fifo_level, 16);
        idle(20, 1'b1);
        checkOutput("full_pp_ovf", ovf, 0);
        checkOutput("bp_pop_count", pops.size(), 20);
        if (pops.size() == 20) begin
            for (int i = 0; i < 16; i++) checkOutput("bp_order", pops[i], i + 1);
            for (int i = 0; i < 4; i++) checkOutput("bp_tail", pops[16 + i], 101 + i);
        end

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 30'sd300000000 - 30'(i), 1'b0, 1'b0);
        idle(12, 1'b0);
        applyStimulus(1'b1, 30'sd8192, 1'b0, 1'b0);
        applyStimulus(1'b1, 30'sd12288, 1'b0, 1'b0);
        checkOutput("pre_rst_level", fifo_level, 8);
        asyncReset();
        vld_cnt = 0;
        idle(20, 1'b1);
        checkOutput("post_rst_valid", vld_cnt, 0);
        checkOutput("post_rst_pops", pops.size(), 0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 1) x = longint'($urandom_range(0, 1 << 27)) - (1 << 26);
            else                           x = longint'($signed(30'($urandom)));
            applyStimulus($urandom_range(0, 99) < 55, 30'(x), $urandom_range(0, 99) < 60,
                          $urandom_range(0, 99) < 3);
        end
        idle(40, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("[TB] FAIL timeout: got %0d cycles expected completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] timeout");
    end

endmodule
